// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns field-level requests into legal instruction words
// and streams them into instruction memory from address 0 upward.
module instr_encoder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_kind_i,
   input  logic [2:0]        req_funct3_i,
   input  logic              req_alt_i,
   input  logic [4:0]        req_rd_i,
   input  logic [4:0]        req_rs1_i,
   input  logic [4:0]        req_rs2_i,
   input  logic [12:0]       req_imm_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic [ADDR_W:0]   word_count_o,
   output logic              reject_o,
   output logic              busy_o,
   output logic              full_o
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   localparam logic [2:0] K_RALU   = 3'd0;
   localparam logic [2:0] K_IALU   = 3'd1;
   localparam logic [2:0] K_LOAD   = 3'd2;
   localparam logic [2:0] K_STORE  = 3'd3;
   localparam logic [2:0] K_BRANCH = 3'd4;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              reject_q, reject_d;
   logic              busy_q, full_q;

   logic [31:0]       word_c;
   logic              legal_c;
   logic              ready_c;
   logic              imm_sext_ok_c;

   assign ready_c       = (state_q == S_RUN) && !start_i && (count_q < DEPTH_C);
   assign req_ready_o   = ready_c;
   assign imm_sext_ok_c = (req_imm_i[12] == req_imm_i[11]);

   // Field packing and legality check for the subset the core decodes.
   always_comb begin
      word_c  = 32'd0;
      legal_c = 1'b0;
      unique case (req_kind_i)
         K_RALU: begin
            word_c  = {(req_alt_i ? 7'b0100000 : 7'b0000000), req_rs2_i, req_rs1_i,
                       req_funct3_i, req_rd_i, 7'b0110011};
            legal_c = !req_alt_i || (req_funct3_i == 3'b000);
         end
         K_IALU: begin
            word_c  = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, 7'b0010011};
            legal_c = imm_sext_ok_c;
            if (req_funct3_i == 3'b000)
               legal_c = legal_c && ((req_imm_i[11:5] == 7'b0000000) ||
                                     (req_imm_i[11:5] == 7'b0100000));
            if ((req_funct3_i == 3'b001) || (req_funct3_i == 3'b101))
               legal_c = legal_c && (req_imm_i[11:5] == 7'b0000000);
         end
         K_LOAD: begin
            word_c  = {req_imm_i[11:0], req_rs1_i, 3'b010, req_rd_i, 7'b0000011};
            legal_c = (req_funct3_i == 3'b010) && imm_sext_ok_c;
         end
         K_STORE: begin
            word_c  = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010, req_imm_i[4:0],
                       7'b0100011};
            legal_c = (req_funct3_i == 3'b010) && imm_sext_ok_c;
         end
         K_BRANCH: begin
            word_c  = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, 3'b000,
                       req_imm_i[4:1], req_imm_i[11], 7'b1100011};
            legal_c = (req_funct3_i == 3'b000) && !req_imm_i[0];
         end
         default: begin
            word_c  = 32'd0;
            legal_c = 1'b0;
         end
      endcase
   end

   // Next state: start overrides everything; an accepted request either writes or rejects.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      reject_d = 1'b0;
      if (start_i) begin
         state_d = S_RUN;
         count_d = '0;
      end else if (req_valid_i && ready_c) begin
         if (legal_c) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(count_q);
            wdata_d = word_c;
            count_d = count_q + CNT_W'(1);
            if (count_d == DEPTH_C)
               state_d = S_FULL;
         end else begin
            reject_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         reject_q <= reject_d;
         busy_q   <= (state_d == S_RUN);
         full_q   <= (state_d == S_FULL);
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign word_count_o = count_q;
   assign reject_o     = reject_q;
   assign busy_o       = busy_q;
   assign full_o       = full_q;

endmodule
